// File: rtl/gci_std_kmc_debounce_nch_if.sv
// Bundle of the debouncer's functional signals. The master side drives raw inputs,
// clear and IRQ acknowledge; the slave side (the debouncer) returns levels and strobes.
interface gci_std_kmc_debounce_nch_if #(
  parameter int unsigned N = 1
) ();
  logic         iCLEAR;
  logic [N-1:0] iDATA;
  logic         iIRQ_ACK;
  logic [N-1:0] oDATA;
  logic [N-1:0] oRISE;
  logic [N-1:0] oFALL;
  logic         oTICK;
  logic         oIRQ;

  modport master (
    output iCLEAR, iDATA, iIRQ_ACK,
    input  oDATA, oRISE, oFALL, oTICK, oIRQ
  );

  modport slave (
    input  iCLEAR, iDATA, iIRQ_ACK,
    output oDATA, oRISE, oFALL, oTICK, oIRQ
  );
endinterface

// File: rtl/gci_std_kmc_debounce_nch.sv
// N-channel chattering canceller: 2-flop synchroniser, sample-tick prescaler, per-channel
// consecutive-difference counter and one-cycle rise/fall strobes.
// Optional sticky change interrupt enabled by defining GCI_STD_KMC_DEBOUNCE_IRQ_EN;
// without it oIRQ is tied low and iIRQ_ACK is ignored.
module gci_std_kmc_debounce_nch #(
  parameter int unsigned N           = 1,
  parameter int unsigned CLK_DIV     = 1250,
  parameter int unsigned STABLE_CNT  = 4,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input logic                       iCLOCK,
  input logic                       inRESET,
  gci_std_kmc_debounce_nch_if.slave io_bus
);
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CW = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] PrescLast = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CntLast   = CW'(STABLE_CNT - 1);

  logic [N-1:0]         r_sync1, r_sync2;
  logic [PW-1:0]        r_presc, w_presc_d;
  logic                 r_tick, w_tick_d;
  logic                 w_tick_now;
  logic [N-1:0]         r_data, w_data_d;
  logic [N-1:0]         r_rise, w_rise_d;
  logic [N-1:0]         r_fall, w_fall_d;
  logic [N-1:0][CW-1:0] r_cnt, w_cnt_d;

  assign w_tick_now = (r_presc == PrescLast);

  // Prescaler next state; a clear overrides a coincident tick.
  always_comb begin
    w_presc_d = r_presc + PW'(1);
    w_tick_d  = 1'b0;
    if (io_bus.iCLEAR) begin
      w_presc_d = '0;
    end else if (w_tick_now) begin
      w_presc_d = '0;
      w_tick_d  = 1'b1;
    end
  end

  // Per-channel acceptance: only a run of STABLE_CNT differing ticks changes the level.
  always_comb begin
    w_cnt_d  = r_cnt;
    w_data_d = r_data;
    w_rise_d = '0;
    w_fall_d = '0;
    if (io_bus.iCLEAR) begin
      w_cnt_d = '0;
    end else if (w_tick_now) begin
      for (int i = 0; i < N; i++) begin
        if (r_sync2[i] == r_data[i]) begin
          w_cnt_d[i] = '0;
        end else if (r_cnt[i] == CntLast) begin
          w_cnt_d[i]  = '0;
          w_data_d[i] = r_sync2[i];
          w_rise_d[i] = r_sync2[i];
          w_fall_d[i] = ~r_sync2[i];
        end else begin
          w_cnt_d[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // State registers: synchroniser, prescaler, levels, strobes and counters.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_sync1 <= {N{RESET_LEVEL}};
      r_sync2 <= {N{RESET_LEVEL}};
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_data  <= {N{RESET_LEVEL}};
      r_rise  <= '0;
      r_fall  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= io_bus.iDATA;
      r_sync2 <= r_sync1;
      r_presc <= w_presc_d;
      r_tick  <= w_tick_d;
      r_data  <= w_data_d;
      r_rise  <= w_rise_d;
      r_fall  <= w_fall_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign io_bus.oDATA = r_data;
  assign io_bus.oRISE = r_rise;
  assign io_bus.oFALL = r_fall;
  assign io_bus.oTICK = r_tick;

`ifdef GCI_STD_KMC_DEBOUNCE_IRQ_EN
  logic r_irq, w_irq_d;

  // Sticky flag: a strobe in the current cycle sets it and beats a coincident ack.
  always_comb begin
    w_irq_d = r_irq;
    if ((|r_rise) || (|r_fall)) begin
      w_irq_d = 1'b1;
    end else if (io_bus.iIRQ_ACK) begin
      w_irq_d = 1'b0;
    end
  end

  // IRQ flag register.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_irq_d;
    end
  end

  assign io_bus.oIRQ = r_irq;
`else
  logic w_unused_ack;
  assign w_unused_ack = io_bus.iIRQ_ACK;
  assign io_bus.oIRQ  = 1'b0;
`endif
endmodule

// File: tb/tb_gci_std_kmc_debounce_nch.sv
module tb_gci_std_kmc_debounce_nch;
  localparam int unsigned N           = 2;
  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned STABLE_CNT  = 3;
  localparam logic        RESET_LEVEL = 1'b0;
`ifdef GCI_STD_KMC_DEBOUNCE_IRQ_EN
  localparam bit IrqOn = 1'b1;
`else
  localparam bit IrqOn = 1'b0;
`endif

  logic iCLOCK  = 1'b0;
  logic inRESET = 1'b1;

  gci_std_kmc_debounce_nch_if #(.N(N)) bus ();

  gci_std_kmc_debounce_nch #(
    .N          (N),
    .CLK_DIV    (CLK_DIV),
    .STABLE_CNT (STABLE_CNT),
    .RESET_LEVEL(RESET_LEVEL)
  ) dut (
    .iCLOCK (iCLOCK),
    .inRESET(inRESET),
    .io_bus (bus.slave)
  );

  always #5 iCLOCK = ~iCLOCK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: levels change when the last STABLE_CNT tick samples (since reset or
  // clear) of the synchronised input all differ from the current level.
  logic [N-1:0]            m_h1, m_h2, m_data, m_rise, m_fall;
  logic                    m_tick, m_irq;
  int                      m_cyc, m_nsmp;
  logic [STABLE_CNT-1:0]   m_win [N];

  task automatic model_reset();
    m_h1 = {N{RESET_LEVEL}};
    m_h2 = {N{RESET_LEVEL}};
    m_data = {N{RESET_LEVEL}};
    m_rise = '0;
    m_fall = '0;
    m_tick = 1'b0;
    m_irq = 1'b0;
    m_cyc = 0;
    m_nsmp = 0;
    for (int c = 0; c < N; c++) m_win[c] = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] sdata;
    logic tick;
    if (IrqOn) begin
      if ((|m_rise) || (|m_fall)) m_irq = 1'b1;
      else if (bus.iIRQ_ACK) m_irq = 1'b0;
    end
    sdata = m_h2;  // input as captured two edges ago
    m_h2 = m_h1;
    m_h1 = bus.iDATA;
    m_rise = '0;
    m_fall = '0;
    if (bus.iCLEAR) begin
      m_cyc = 0;
      m_nsmp = 0;
      m_tick = 1'b0;
    end else begin
      tick = (m_cyc % CLK_DIV) == (CLK_DIV - 1);
      m_cyc++;
      m_tick = tick;
      if (tick) begin
        if (m_nsmp < STABLE_CNT) m_nsmp++;
        for (int c = 0; c < N; c++) begin
          m_win[c] = (m_win[c] << 1) | STABLE_CNT'(sdata[c]);
          if (m_nsmp == STABLE_CNT && m_win[c] == {STABLE_CNT{~m_data[c]}}) begin
            m_rise[c] = ~m_data[c];
            m_fall[c] = m_data[c];
            m_data[c] = ~m_data[c];
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge iCLOCK or negedge inRESET);
      if (!inRESET) model_reset();
      else model_step();
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge iCLOCK) begin
    chk("cmp_oDATA", 32'(bus.oDATA), 32'(m_data));
    chk("cmp_oRISE", 32'(bus.oRISE), 32'(m_rise));
    chk("cmp_oFALL", 32'(bus.oFALL), 32'(m_fall));
    chk("cmp_oTICK", 32'(bus.oTICK), 32'(m_tick));
    chk("cmp_oIRQ",  32'(bus.oIRQ),  32'(m_irq));
  end

  task automatic step(input int n);
    repeat (n) @(posedge iCLOCK);
    #1;
  endtask

  initial begin
    int t1, t2, lat, cnt, cnt2;
    bit found;
    bus.iDATA = '0;
    bus.iCLEAR = 1'b0;
    bus.iIRQ_ACK = 1'b0;

    // Reset held with inputs high.
    #1 inRESET = 1'b0;
    bus.iDATA = 2'b11;
    step(3);
    chk("rst_oDATA", 32'(bus.oDATA), 32'h0);
    chk("rst_oRISE", 32'(bus.oRISE), 32'h0);
    chk("rst_oFALL", 32'(bus.oFALL), 32'h0);
    chk("rst_oTICK", 32'(bus.oTICK), 32'h0);
    chk("rst_oIRQ",  32'(bus.oIRQ),  32'h0);
    bus.iDATA = 2'b00;
    inRESET = 1'b1;
    t1 = -1;
    t2 = -1;
    for (int c = 1; c <= 12; c++) begin
      step(1);
      if (bus.oTICK) begin
        if (t1 < 0) t1 = c;
        else if (t2 < 0) t2 = c;
      end
    end
    chk("tick_first", 32'(t1), 32'd4);
    chk("tick_second", 32'(t2), 32'd8);

    // Step on channel 0: single rise, then single fall.
    bus.iDATA = 2'b01;
    lat = -1;
    cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (bus.oRISE[0]) begin
        cnt++;
        if (lat < 0) lat = c;
      end
    end
    chk("step_rise_count", 32'(cnt), 32'd1);
    chk("step_rise_in_15", 32'(lat >= 1 && lat <= 15), 32'd1);
    chk("step_oDATA_hi", 32'(bus.oDATA), 32'h1);
    bus.iDATA = 2'b00;
    cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (bus.oFALL[0]) cnt++;
    end
    chk("step_fall_count", 32'(cnt), 32'd1);
    chk("step_oDATA_lo", 32'(bus.oDATA), 32'h0);

    // Chatter: toggle every 5 cycles; never 3 equal consecutive tick samples.
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      if (c % 5 == 0) bus.iDATA[0] = ~bus.iDATA[0];
      step(1);
      if ((|bus.oRISE) || (|bus.oFALL)) cnt++;
    end
    chk("chatter_strobes", 32'(cnt), 32'd0);
    chk("chatter_oDATA", 32'(bus.oDATA), 32'h0);
    bus.iDATA = 2'b00;
    step(20);

    // Near-miss on channel 1: 8 cycles spans exactly 2 ticks, 12 cycles exactly 3.
    cnt = 0;
    bus.iDATA[1] = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c == 8) bus.iDATA[1] = 1'b0;
      step(1);
      if (bus.oRISE[1]) cnt++;
    end
    chk("nearmiss_rise", 32'(cnt), 32'd0);
    chk("nearmiss_oDATA", 32'(bus.oDATA), 32'h0);
    cnt = 0;
    bus.iDATA[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 12) bus.iDATA[1] = 1'b0;
      step(1);
      if (bus.oRISE[1]) cnt++;
    end
    chk("threetick_rise", 32'(cnt), 32'd1);
    step(30);
    chk("threetick_settle", 32'(bus.oDATA), 32'h0);

    // Clear after two differing ticks restarts the count.
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      step(1);
      if (bus.oTICK) found = 1'b1;
    end
    chk("clr_tick_found", 32'(found), 32'd1);
    bus.iDATA[0] = 1'b1;
    step(8);
    bus.iCLEAR = 1'b1;
    step(1);
    bus.iCLEAR = 1'b0;
    chk("clr_hold_oDATA", 32'(bus.oDATA), 32'h0);
    chk("clr_no_strobe", 32'(bus.oRISE | bus.oFALL), 32'h0);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (bus.oRISE[0] && lat < 0) lat = c;
    end
    chk("clr_rise_latency", 32'(lat), 32'd12);
    bus.iDATA = 2'b00;
    step(30);

    // IRQ behaviour (stays low when the feature is compiled out).
    bus.iIRQ_ACK = 1'b1;
    step(1);
    bus.iIRQ_ACK = 1'b0;
    chk("irq_ack_clear", 32'(bus.oIRQ), 32'd0);
    bus.iDATA = 2'b11;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step(1);
      if (bus.oRISE == 2'b11) found = 1'b1;
    end
    chk("irq_dual_rise", 32'(found), 32'd1);
    step(1);
    chk("irq_set", 32'(bus.oIRQ), 32'(IrqOn));
    bus.iIRQ_ACK = 1'b1;
    step(1);
    bus.iIRQ_ACK = 1'b0;
    chk("irq_acked", 32'(bus.oIRQ), 32'd0);
    bus.iDATA = 2'b00;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step(1);
      if (bus.oFALL != 2'b00) found = 1'b1;
    end
    chk("irq_fall_seen", 32'(found), 32'd1);
    bus.iIRQ_ACK = 1'b1;
    step(1);
    bus.iIRQ_ACK = 1'b0;
    chk("irq_set_wins", 32'(bus.oIRQ), 32'(IrqOn));
    step(10);

    // Randomised phase with clears, acks and occasional mid-count resets.
    cnt2 = 0;
    for (int i = 0; i < 4000; i++) begin
      int div;
      div = 4 + 8 * (i / 1000);
      if ($urandom_range(0, 999) < 3) begin
        #2 inRESET = 1'b0;
        step(2);
        inRESET = 1'b1;
        cnt2++;
      end
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, div - 1) == 0) bus.iDATA[c] = ~bus.iDATA[c];
      bus.iCLEAR = ($urandom_range(0, 149) == 0);
      bus.iIRQ_ACK = ($urandom_range(0, 15) == 0);
      step(1);
    end
    bus.iCLEAR = 1'b0;
    bus.iIRQ_ACK = 1'b0;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
